// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: groups the control, target and status signals of pc_ras_unit.
//   master : drives stall, pc_src, branch_imm, jump_imm, redirect_valid, redirect_addr;
//            observes pc, halted and the return-address-stack status.
//   slave  : the PC/RAS unit itself (sees the controls, drives the status).
interface pc_ras_unit_if #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RAS_DEPTH = 8
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic              stall;
   logic [2:0]        pc_src;
   logic [ADDR_W-1:0] branch_imm;
   logic [ADDR_W-1:0] jump_imm;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;

   logic [ADDR_W-1:0] pc;
   logic              halted;
   logic [CNT_W-1:0]  ras_count;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_overflow;
   logic              ras_underflow;

   modport master (
      output stall, pc_src, branch_imm, jump_imm, redirect_valid, redirect_addr,
      input  pc, halted, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
   );

   modport slave (
      input  stall, pc_src, branch_imm, jump_imm, redirect_valid, redirect_addr,
      output pc, halted, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
   );
endinterface

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with a circular return-address stack.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; overrides every other input
//   bus   : pc_ras_unit_if.slave
//           in  stall, pc_src (0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RETURN, 5-7 SEQ),
//               branch_imm, jump_imm (signed offsets), redirect_valid, redirect_addr
//           out pc, halted, ras_count, ras_empty, ras_full, ras_overflow, ras_underflow
// RETURN on an empty stack halts the unit until a redirect or reset.
module pc_ras_unit #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       RAS_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       PC_INC    = 4
) (
   input logic          clock,
   input logic          reset,
   pc_ras_unit_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [2:0] SRC_SEQ    = 3'd0;
   localparam logic [2:0] SRC_BRANCH = 3'd1;
   localparam logic [2:0] SRC_JUMP   = 3'd2;
   localparam logic [2:0] SRC_CALL   = 3'd3;
   localparam logic [2:0] SRC_RETURN = 3'd4;

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;

   logic [ADDR_W-1:0] stack [RAS_DEPTH];
   logic              push_en;
   logic [ADDR_W-1:0] seq_pc;
   logic [PTR_W-1:0]  top_idx;
   logic              full;

   assign seq_pc  = pc_q + ADDR_W'(PC_INC);
   // wr_ptr names the next free slot; the newest entry sits just below it.
   // Power-of-two depth lets the pointer wrap naturally, so a push on a
   // full stack overwrites the oldest entry.
   assign top_idx = wr_ptr_q - PTR_W'(1);
   assign full    = (count_q == CNT_W'(RAS_DEPTH));

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      push_en     = 1'b0;

      if (bus.redirect_valid) begin
         pc_d    = bus.redirect_addr;
         state_d = StRun;
      end else if (!bus.stall && state_q == StRun) begin
         case (bus.pc_src)
            SRC_BRANCH: pc_d = pc_q + bus.branch_imm;
            SRC_JUMP:   pc_d = pc_q + bus.jump_imm;
            SRC_CALL: begin
               pc_d     = pc_q + bus.jump_imm;
               push_en  = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               if (full) begin
                  overflow_d = 1'b1;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            SRC_RETURN: begin
               if (count_q != '0) begin
                  pc_d     = stack[top_idx];
                  wr_ptr_d = top_idx;
                  count_d  = count_q - CNT_W'(1);
               end else begin
                  underflow_d = 1'b1;
                  state_d     = StHalt;
               end
            end
            default: pc_d = seq_pc; // SRC_SEQ and unused encodings 5-7
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StRun;
         pc_q        <= RESET_PC;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Stack storage carries no reset; ras_count alone defines validity.
   always_ff @(posedge clock) begin
      if (!reset && push_en) begin
         stack[wr_ptr_q] <= seq_pc;
      end
   end

   assign bus.pc            = pc_q;
   assign bus.halted        = (state_q == StHalt);
   assign bus.ras_count     = count_q;
   assign bus.ras_empty     = (count_q == '0);
   assign bus.ras_full      = full;
   assign bus.ras_overflow  = overflow_q;
   assign bus.ras_underflow = underflow_q;
endmodule
